// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline stall/flush/halt control with a saturating stall-cycle counter
module hazard_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             MemRead_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    input  logic             ecall_wb,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_write,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, HALTED = 2'd2;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             load_use, freeze;
    always_comb begin
        load_use = MemRead_ex && |rd_ex &&
                   ((use_rs1_id && rs1_id == rd_ex) || (use_rs2_id && rs2_id == rd_ex));
        // once waiting, only dmem_ready releases the freeze, whatever dmem_req_mem does
        freeze = (state_q == MEM_WAIT) ? !dmem_ready : dmem_req_mem && !dmem_ready;
        state_d = state_q;
        pc_write = 1'b1;
        ifid_write = 1'b1;
        exmem_write = 1'b1;
        memwb_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        halted = 1'b0;
        if (reset || state_q == HALTED || ecall_wb || freeze) begin
            pc_write = 1'b0;
            ifid_write = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
        end
        if (reset) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d = RUN;
        end else if (state_q == HALTED) begin
            halted = 1'b1;
        end else if (ecall_wb) begin
            state_d = HALTED;
        end else if (freeze) begin
            state_d = MEM_WAIT;
        end else begin
            state_d = RUN;
            ifid_flush = branch_taken_ex;
            idex_flush = branch_taken_ex || load_use;
            pc_write = branch_taken_ex || !load_use;
            ifid_write = branch_taken_ex || !load_use;
        end
        stall_cycles_d = reset ? '0 :
                         (!pc_write && stall_cycles_q != '1) ? stall_cycles_q + 1'b1 : stall_cycles_q;
    end
    always_ff @(posedge clk) begin
        state_q <= state_d;
        stall_cycles_q <= stall_cycles_d;
    end
    assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed and random checks of hazard_sequencer against a behavioural model
module tb_hazard_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        use_rs1_id, use_rs2_id, MemRead_ex, branch_taken_ex, dmem_req_mem, dmem_ready, ecall_wb;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_write, halted;
    logic [15:0] stall_cycles;
    logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_flush, b_exmem_write, b_memwb_write, b_halted;
    logic [1:0]  b_stall_cycles;
    int          checks = 0, errors = 0;
    int          mode_m = 0;
    int          cnt_m = 0;

    hazard_sequencer dut (
        .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex), .MemRead_ex(MemRead_ex),
        .branch_taken_ex(branch_taken_ex), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .ecall_wb(ecall_wb), .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_write(exmem_write), .memwb_write(memwb_write),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    hazard_sequencer #(.CNT_W(2)) dut_w2 (
        .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex), .MemRead_ex(MemRead_ex),
        .branch_taken_ex(branch_taken_ex), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .ecall_wb(ecall_wb), .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
        .idex_flush(b_idex_flush), .exmem_write(b_exmem_write), .memwb_write(b_memwb_write),
        .halted(b_halted), .stall_cycles(b_stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode_m: 0 running, 1 waiting on memory, 2 halted; expected vector is {pc_w, ifid_w, ifid_fl, idex_fl, exmem_w, memwb_w, halted}
    task automatic step(input bit rst_i, input bit [4:0] r1, input bit [4:0] r2, input bit u1, input bit u2,
                        input bit [4:0] rd, input bit mr, input bit br, input bit rq, input bit rdy, input bit ec);
        logic [6:0] e;
        int nmode;
        bit lu;
        @(negedge clk);
        reset = rst_i; rs1_id = r1; rs2_id = r2; use_rs1_id = u1; use_rs2_id = u2;
        rd_ex = rd; MemRead_ex = mr; branch_taken_ex = br; dmem_req_mem = rq; dmem_ready = rdy; ecall_wb = ec;
        #1;
        lu = mr && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
        nmode = mode_m;
        if (rst_i) begin
            e = 7'b0011000;
            nmode = 0;
        end else if (mode_m == 2) begin
            e = 7'b0000001;
        end else if (ec) begin
            e = 7'b0000000;
            nmode = 2;
        end else if (mode_m == 1 ? !rdy : (rq && !rdy)) begin
            e = 7'b0000000;
            nmode = 1;
        end else begin
            nmode = 0;
            e = br ? 7'b1111110 : lu ? 7'b0001110 : 7'b1100110;
        end
        chk("ctl16", {pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_write, halted}, e);
        chk("ctl2", {b_pc_write, b_ifid_write, b_ifid_flush, b_idex_flush, b_exmem_write, b_memwb_write, b_halted}, e);
        chk("cnt16", stall_cycles, (cnt_m > 65535) ? 65535 : cnt_m);
        chk("cnt2", b_stall_cycles, (cnt_m > 3) ? 3 : cnt_m);
        @(posedge clk);
        mode_m = nmode;
        cnt_m = rst_i ? 0 : cnt_m + (e[6] ? 0 : 1);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        #1 chk("after_reset_cnt", stall_cycles, 0);
        step(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
        #1 chk("load_use_cnt", stall_cycles, 1);
        step(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 7, 0, 0, 7, 1, 0, 0, 0, 0);
        #1 chk("x0_unused_cnt", stall_cycles, 1);
        step(0, 9, 0, 1, 0, 9, 1, 1, 0, 0, 0);
        #1 chk("branch_over_lu_cnt", stall_cycles, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        #1 chk("memwait_branch_cnt", stall_cycles, 3);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        #1 chk("sat_cnt2", b_stall_cycles, 3);
        chk("sat_cnt16", stall_cycles, 6);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        repeat (4) step(0, 3, 3, 1, 1, 3, 1, 1, 1, 1, 0);
        #1 chk("halted_hold", halted, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        #1 chk("post_halt_reset_halted", halted, 0);
        chk("post_halt_reset_cnt", stall_cycles, 0);
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 39) == 0) || (mode_m == 2 && $urandom_range(0, 4) == 0),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 59) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
